// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      HANDLER
   } trap_state_e;

   localparam int unsigned CAUSE_MSI        = 3;
   localparam int unsigned CAUSE_MTI        = 7;
   localparam int unsigned CAUSE_MEI        = 11;
   localparam int unsigned CAUSE_LOCAL_BASE = 16;
   localparam int unsigned MAX_XLEN         = 64;
   localparam int unsigned CNT_W            = 2;

   // Interrupt mcause: top bit of an xlen-wide word set, code in the low bits.
   function automatic logic [MAX_XLEN-1:0] intr_mcause(input int unsigned xlen,
                                                       input logic [7:0]  code);
      logic [MAX_XLEN-1:0] c;
      c = MAX_XLEN'(code);
      c = c | (MAX_XLEN'(1) << (xlen - 1));
      return c;
   endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR/pipeline-facing bundle of the trap controller.
interface trap_ctrl_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned EXC_W = 5
);
   logic [XLEN-1:0]  mie;
   logic [XLEN-1:0]  mip;
   logic [XLEN-1:0]  mstatus;
   logic             exc_valid;
   logic [EXC_W-1:0] exc_code;
   logic             mret_commit;
   logic             trap_flush;
   logic             intr_happen;
   logic             ex_happen;
   logic [XLEN-1:0]  trap_cause;
   logic             trap_active;
   logic             trap_fin;

   modport master (
      output mie, mip, mstatus, exc_valid, exc_code, mret_commit,
      input  trap_flush, intr_happen, ex_happen, trap_cause, trap_active, trap_fin
   );

   modport slave (
      input  mie, mip, mstatus, exc_valid, exc_code, mret_commit,
      output trap_flush, intr_happen, ex_happen, trap_cause, trap_active, trap_fin
   );
endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > local[0] > ... > local[N-1].
module trap_prio_enc
   import trap_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_LOCAL = 16,
   parameter int unsigned CODE_W    = $clog2(XLEN)
) (
   input  logic [XLEN-1:0]   pend,
   output logic              any_valid,
   output logic [CODE_W-1:0] code
);

   logic [XLEN-1:0] shifted;

   // Walk locals from highest to lowest so the lowest index overrides; standard
   // sources are applied last in ascending priority so MEI wins overall.
   always_comb begin
      any_valid = 1'b0;
      code      = '0;
      shifted   = '0;
      for (int unsigned i = NUM_LOCAL; i > 0; i--) begin
         shifted = pend >> (CAUSE_LOCAL_BASE + i - 1);
         if (shifted[0]) begin
            any_valid = 1'b1;
            code      = CODE_W'(CAUSE_LOCAL_BASE + i - 1);
         end
      end
      if (pend[CAUSE_MTI]) begin
         any_valid = 1'b1;
         code      = CODE_W'(CAUSE_MTI);
      end
      if (pend[CAUSE_MSI]) begin
         any_valid = 1'b1;
         code      = CODE_W'(CAUSE_MSI);
      end
      if (pend[CAUSE_MEI]) begin
         any_valid = 1'b1;
         code      = CODE_W'(CAUSE_MEI);
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates interrupts/exceptions, pulses a
// pipeline flush with mcause, then tracks the handler until mret commits.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_LOCAL = 16,
   parameter int unsigned EXC_W     = 5,
   parameter int unsigned COOLDOWN  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   trap_ctrl_if.slave  bus
);

   localparam int unsigned CODE_W = $clog2(XLEN);

   localparam logic [XLEN-1:0] STD_MASK =
      (XLEN'(1) << CAUSE_MEI) | (XLEN'(1) << CAUSE_MSI) | (XLEN'(1) << CAUSE_MTI);
   localparam logic [XLEN-1:0] LOCAL_MASK =
      ((XLEN'(1) << NUM_LOCAL) - XLEN'(1)) << CAUSE_LOCAL_BASE;
   localparam logic [XLEN-1:0] IRQ_MASK = STD_MASK | LOCAL_MASK;

   trap_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              flush_q, flush_d;
   logic              intr_q, intr_d;
   logic              ex_q, ex_d;
   logic              active_q, active_d;
   logic [XLEN-1:0]   cause_q, cause_d;

   logic [XLEN-1:0]   pend;
   logic              irq_any;
   logic [CODE_W-1:0] irq_code;
   logic              unused_mstatus;

   assign pend           = bus.mip & bus.mie & IRQ_MASK & {XLEN{bus.mstatus[3]}};
   assign unused_mstatus = ^{bus.mstatus[XLEN-1:4], bus.mstatus[2:0]};

   trap_prio_enc #(
      .XLEN      (XLEN),
      .NUM_LOCAL (NUM_LOCAL),
      .CODE_W    (CODE_W)
   ) u_prio (
      .pend      (pend),
      .any_valid (irq_any),
      .code      (irq_code)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      intr_d  = 1'b0;
      ex_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            // Cooldown gates interrupts only; exceptions are always accepted.
            if (bus.exc_valid) begin
               state_d = FLUSH;
               ex_d    = 1'b1;
               cause_d = XLEN'(bus.exc_code);
            end else if (irq_any && (cnt_q == '0)) begin
               state_d = FLUSH;
               intr_d  = 1'b1;
               cause_d = XLEN'(intr_mcause(XLEN, 8'(irq_code)));
            end
         end
         FLUSH: state_d = HANDLER;
         HANDLER: begin
            if (bus.exc_valid) begin
               state_d = FLUSH;
               ex_d    = 1'b1;
               cause_d = XLEN'(bus.exc_code);
            end else if (bus.mret_commit) begin
               state_d = IDLE;
               cnt_d   = CNT_W'(COOLDOWN);
            end
         end
         default: state_d = IDLE;
      endcase
      flush_d  = (state_d == FLUSH);
      active_d = (state_d == HANDLER);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         flush_q  <= 1'b0;
         intr_q   <= 1'b0;
         ex_q     <= 1'b0;
         active_q <= 1'b0;
         cause_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         intr_q   <= intr_d;
         ex_q     <= ex_d;
         active_q <= active_d;
         cause_q  <= cause_d;
      end
   end

   assign bus.trap_flush  = flush_q;
   assign bus.intr_happen = intr_q;
   assign bus.ex_happen   = ex_q;
   assign bus.trap_cause  = cause_q;
   assign bus.trap_active = active_q;
   assign bus.trap_fin    = bus.mret_commit;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed stimulus pushes expected flushes,
// a negedge monitor pops and compares whenever trap_flush is seen.
module tb_trap_ctrl;

   typedef struct {
      int          cyc;
      bit          intr;
      bit          ex;
      logic [31:0] cause;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t mon_e;

   trap_ctrl_if #(.XLEN(32), .EXC_W(5)) bus ();

   trap_ctrl #(
      .XLEN      (32),
      .NUM_LOCAL (16),
      .EXC_W     (5),
      .COOLDOWN  (1)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic expect_trap(input bit intr, input bit ex, input logic [31:0] cause);
      exp_t e;
      e.cyc = cyc + 1; e.intr = intr; e.ex = ex; e.cause = cause;
      sb.push_back(e);
   endtask

   // Called at a negedge while in HANDLER; retires the handler and, with
   // COOLDOWN=1, expects the next interrupt three edges later.
   task automatic handler_mret(input logic [31:0] m, input bit has, input logic [31:0] cause);
      exp_t e;
      bus.mip = m;
      bus.mret_commit = 1'b1;
      if (has) begin
         e.cyc = cyc + 3; e.intr = 1'b1; e.ex = 1'b0; e.cause = cause;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.mret_commit = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (bus.trap_flush === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_flush", 64'(bus.trap_flush), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("flush_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("intr_happen", 64'(bus.intr_happen), 64'(mon_e.intr));
            chk("ex_happen", 64'(bus.ex_happen), 64'(mon_e.ex));
            chk("trap_cause", 64'(bus.trap_cause), 64'(mon_e.cause));
         end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
         chk("missing_flush", 64'(bus.trap_flush), 64'd1);
         void'(sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn          = 1'b0;
      bus.mie         = '0;
      bus.mip         = '0;
      bus.mstatus     = '0;
      bus.exc_valid   = 1'b0;
      bus.exc_code    = '0;
      bus.mret_commit = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_flush", 64'(bus.trap_flush), 64'd0);
      chk("rst_intr", 64'(bus.intr_happen), 64'd0);
      chk("rst_ex", 64'(bus.ex_happen), 64'd0);
      chk("rst_cause", 64'(bus.trap_cause), 64'd0);
      chk("rst_active", 64'(bus.trap_active), 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // T1: single MEI
      bus.mstatus = 32'h8;
      bus.mie     = 32'h800;
      bus.mip     = 32'h800;
      expect_trap(1'b1, 1'b0, 32'h8000000B);
      @(negedge clk);
      bus.mip = '0;
      @(negedge clk);
      chk("t1_active", 64'(bus.trap_active), 64'd1);
      chk("t1_flush_one_cycle", 64'(bus.trap_flush), 64'd0);
      bus.mret_commit = 1'b1;
      #1 chk("t1_trap_fin", 64'(bus.trap_fin), 64'd1);
      @(negedge clk);
      bus.mret_commit = 1'b0;
      chk("t1_idle", 64'(bus.trap_active), 64'd0);
      chk("t1_cause_held", 64'(bus.trap_cause), 64'h8000000B);
      repeat (2) @(negedge clk);

      // T2: priority chain with cooldown
      bus.mie = 32'h00030888;
      bus.mip = 32'h00030888;
      expect_trap(1'b1, 1'b0, 32'h8000000B);
      repeat (2) @(negedge clk);
      handler_mret(32'h00030088, 1'b1, 32'h80000003);
      handler_mret(32'h00030080, 1'b1, 32'h80000007);
      handler_mret(32'h00030000, 1'b1, 32'h80000010);
      handler_mret(32'h00020000, 1'b1, 32'h80000011);
      handler_mret(32'h00000000, 1'b0, 32'h0);
      chk("t2_idle", 64'(bus.trap_active), 64'd0);

      // T3: exception beats a pending MEI
      bus.mip       = 32'h800;
      bus.exc_valid = 1'b1;
      bus.exc_code  = 5'd2;
      expect_trap(1'b0, 1'b1, 32'h00000002);
      @(negedge clk);
      bus.exc_valid = 1'b0;
      bus.mip       = '0;
      @(negedge clk);

      // T4: exception and mret together in HANDLER
      bus.exc_valid   = 1'b1;
      bus.exc_code    = 5'd11;
      bus.mret_commit = 1'b1;
      expect_trap(1'b0, 1'b1, 32'h0000000B);
      @(negedge clk);
      bus.exc_valid   = 1'b0;
      bus.mret_commit = 1'b0;
      @(negedge clk);
      chk("t4_active", 64'(bus.trap_active), 64'd1);
      bus.mret_commit = 1'b1;
      @(negedge clk);
      bus.mret_commit = 1'b0;
      repeat (2) @(negedge clk);

      // T5: global MIE clear blocks interrupts, not exceptions
      bus.mstatus = 32'h0;
      bus.mie     = 32'h80;
      bus.mip     = 32'h80;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t5_no_flush", 64'(bus.trap_flush), 64'd0);
      end
      bus.exc_valid = 1'b1;
      bus.exc_code  = 5'd3;
      expect_trap(1'b0, 1'b1, 32'h00000003);
      @(negedge clk);
      bus.exc_valid = 1'b0;
      @(negedge clk);

      // T6: async reset mid-HANDLER, then MTI after release
      bus.mstatus = 32'h8;
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_active", 64'(bus.trap_active), 64'd0);
      chk("t6_rst_flush", 64'(bus.trap_flush), 64'd0);
      chk("t6_rst_intr", 64'(bus.intr_happen), 64'd0);
      chk("t6_rst_ex", 64'(bus.ex_happen), 64'd0);
      chk("t6_rst_cause", 64'(bus.trap_cause), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      expect_trap(1'b1, 1'b0, 32'h80000007);
      @(negedge clk);
      bus.mip = '0;
      @(negedge clk);
      chk("t6_active", 64'(bus.trap_active), 64'd1);
      bus.mret_commit = 1'b1;
      @(negedge clk);
      bus.mret_commit = 1'b0;
      repeat (3) @(negedge clk);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised machine-mode trap controller, the successor to the fixed three-source interrupt handler.
- Arbitrates standard interrupts MEI/MSI/MTI, NUM_LOCAL platform-local interrupts (mip[16+i]) and synchronous exceptions from the pipeline.
- Issues a one-cycle flush with cause, then tracks handler occupancy until mret commits.
- Sits between the CSR file (mie/mip/mstatus) and the pipeline flush/redirect logic.

Parameters:
XLEN, 32, CSR and cause width.
NUM_LOCAL, 16, number of local interrupt lines; legal range 0..XLEN-16.
EXC_W, 5, width of exception code input.
COOLDOWN, 1, idle cycles after mret before interrupts are re-sampled (0..3).

Ports:
clk  in  1  clock.
resetn  in  1  reset, asynchronous, active-low.
mie  in  XLEN  CSR mie.
mip  in  XLEN  CSR mip; bits 3/7/11 standard, bits 16..16+NUM_LOCAL-1 local.
mstatus  in  XLEN  CSR mstatus; only bit 3 (MIE) used.
exc_valid  in  1  pipeline reports a synchronous exception this cycle.
exc_code  in  EXC_W  exception code, valid with exc_valid.
mret_commit  in  1  mret retired this cycle.
trap_flush  out  1  one-cycle pulse: flush pipeline and redirect to mtvec.
intr_happen  out  1  with trap_flush: the trap is an interrupt.
ex_happen  out  1  with trap_flush: the trap is an exception.
trap_cause  out  XLEN  mcause value, held from flush until the next trap.
trap_active  out  1  a handler is in progress (HANDLER state).
trap_fin  out  1  combinational copy of mret_commit.

Behaviour:
- Reset (async, resetn=0): state IDLE, cooldown counter 0, all registered outputs 0.
- Eligible interrupt set: mip & mie, restricted to bits 3, 7, 11 and 16..16+NUM_LOCAL-1; eligible only when mstatus[3]=1.
- Priority:
  - Exception over all interrupts.
  - Among interrupts: MEI(11) > MSI(3) > MTI(7) > local[0] > local[1] > ... > local[NUM_LOCAL-1].
- Cause encoding:
  - Interrupt: bit XLEN-1 = 1, low bits = code (11, 3, 7, or 16+i).
  - Exception: bit XLEN-1 = 0, low EXC_W bits = exc_code, remaining bits zero.
- States:
  - IDLE:
    - exc_valid -> FLUSH.
    - Else, an eligible interrupt exists and cooldown counter = 0 -> FLUSH.
    - Cause is registered on the transition edge.
  - FLUSH (exactly 1 cycle):
    - trap_flush=1, and intr_happen or ex_happen =1 (never both).
    - exc_valid and interrupts are ignored this cycle.
    - Next state HANDLER.
  - HANDLER:
    - trap_active=1; interrupts are not taken (no nesting).
    - exc_valid -> FLUSH with new exception cause.
    - Else mret_commit -> IDLE with cooldown counter loaded to COOLDOWN.
    - If exc_valid and mret_commit arrive together, the exception wins.
- Cooldown:
  - Counter decrements each IDLE cycle while nonzero.
  - Blocks interrupts only; exceptions are accepted during cooldown.
  - Covers the mip update lag after the handler clears its source.
- Latency: stimulus at cycle N -> trap_flush high in cycle N+1 (registered).
- trap_flush, intr_happen and ex_happen are high only in the FLUSH cycle.
- trap_cause holds its value until the next FLUSH; it is not cleared on mret.
- mstatus[3] dropping while in HANDLER has no effect on state.
- Source deasserting in the same cycle the cause is sampled: the trap is still taken with the sampled cause.
- NUM_LOCAL=0: local logic elaborates away; behaviour is identical to the standard-only case.
- Reset asserted mid-FLUSH or mid-HANDLER: immediate return to IDLE, outputs 0, no pending trap remembered.

Decomposition:
- Package trap_pkg:
  - State enum (IDLE, FLUSH, HANDLER).
  - Code constants CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11, CAUSE_LOCAL_BASE=16.
  - Function building an interrupt mcause from a code.
- One sub-module, trap_prio_enc: combinational, parametrised by NUM_LOCAL.
  - Input: masked pending vector.
  - Outputs: any_valid, selected code.
  - Instantiated once in trap_ctrl beside the FSM and cooldown counter.

Test Plan:
1. mstatus[3]=1, mie=mip=0x800 -> trap_flush pulse 1 cycle later, intr_happen=1, trap_cause=0x8000000B, trap_active=1 the next cycle.
2. mie=mip=0x00030888, MIE=1 -> MEI chosen (0x8000000B). After mret with mip=0x00030088, COOLDOWN=1 -> one blocked cycle, then MSI taken (0x80000003). Subsequent mrets yield MTI (0x80000007), then local 0 (0x80000010), then local 1 (0x80000011).
3. exc_valid=1, exc_code=2, same cycle as MEI pending, MIE=1 -> ex_happen=1, intr_happen=0, trap_cause=0x00000002.
4. In HANDLER, exc_valid (code 11) and mret_commit in the same cycle -> FLUSH again, trap_cause=0x0000000B, state stays non-IDLE.
5. MIE=0, mip=mie=0x80 -> no flush for 20 cycles. Then exc_valid with code 3 -> flush with cause 0x00000003.
6. resetn pulsed low asynchronously mid-HANDLER -> all outputs 0 with no clock edge. After release with MTI pending and MIE=1 -> flush within 1 cycle.
